// File: rtl/ahbl_to_apb_pkg.sv
// Shared AHB-lite / APB bus definitions: transfer and size codes plus the
// one-hot state encoding of the AHB-lite to APB bridge.
package ahbl_to_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [6:0] {
    S_IDLE   = 7'b0000001,
    S_WDATA  = 7'b0000010,
    S_SETUP  = 7'b0000100,
    S_ACCESS = 7'b0001000,
    S_RESP   = 7'b0010000,
    S_ERR1   = 7'b0100000,
    S_ERR2   = 7'b1000000
  } bridge_state_e;

endpackage

// File: rtl/ahbl_apb_strb_decode.sv
// Combinational byte-strobe decode from AHB transfer size and the low
// address bits of a 32-bit data bus.
module ahbl_apb_strb_decode
  import ahbl_to_apb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] haddr_lo,
  output logic [3:0] pstrb
);

  always_comb begin
    pstrb = 4'hf;
    case (hsize)
      HSIZE_BYTE: pstrb = 4'b0001 << haddr_lo;
      HSIZE_HALF: pstrb = haddr_lo[1] ? 4'b1100 : 4'b0011;
      default:    pstrb = 4'hf;
    endcase
  end

endmodule

// File: rtl/ahbl_to_apb.sv
// AHB-lite slave to APB4 master bridge: one APB SETUP/ACCESS per accepted
// AHB transfer, AHB data phase stalled until the completer answers.
module ahbl_to_apb
  import ahbl_to_apb_pkg::*;
#(
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32,
  parameter int W_PADDR = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ahbls_hready,
  output logic               ahbls_hready_resp,
  output logic               ahbls_hresp,
  input  logic [W_ADDR-1:0]  ahbls_haddr,
  input  logic               ahbls_hwrite,
  input  logic [1:0]         ahbls_htrans,
  input  logic [2:0]         ahbls_hsize,
  input  logic [2:0]         ahbls_hburst,
  input  logic [3:0]         ahbls_hprot,
  input  logic               ahbls_hmastlock,
  input  logic [W_DATA-1:0]  ahbls_hwdata,
  output logic [W_DATA-1:0]  ahbls_hrdata,
  input  logic               ahbls_hexcl,
  output logic               ahbls_hexokay,
  output logic [W_PADDR-1:0] apbm_paddr,
  output logic               apbm_psel,
  output logic               apbm_penable,
  output logic               apbm_pwrite,
  output logic [W_DATA-1:0]  apbm_pwdata,
  output logic [3:0]         apbm_pstrb,
  input  logic [W_DATA-1:0]  apbm_prdata,
  input  logic               apbm_pready,
  input  logic               apbm_pslverr
);

  bridge_state_e      state_q, state_d;
  logic [W_PADDR-1:0] paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [3:0]         pstrb_q, pstrb_d;
  logic [W_DATA-1:0]  pwdata_q, pwdata_d;
  logic [W_DATA-1:0]  hrdata_q, hrdata_d;
  logic [3:0]         strb_dec;
  logic               accept;

  // Burst/protection/lock carry no meaning for APB; exclusives run as normal.
  logic unused_inputs;
  assign unused_inputs = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hexcl,
                           ahbls_htrans[0], ahbls_haddr[W_ADDR-1:W_PADDR]};

  ahbl_apb_strb_decode u_strb_decode (
    .hsize    (ahbls_hsize),
    .haddr_lo (ahbls_haddr[1:0]),
    .pstrb    (strb_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pstrb_q  <= pstrb_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    paddr_d           = paddr_q;
    pwrite_d          = pwrite_q;
    pstrb_d           = pstrb_q;
    pwdata_d          = pwdata_q;
    hrdata_d          = hrdata_q;
    ahbls_hready_resp = state_q inside {S_IDLE, S_RESP, S_ERR2};
    ahbls_hresp       = state_q inside {S_ERR1, S_ERR2};
    apbm_psel         = state_q inside {S_SETUP, S_ACCESS};
    apbm_penable      = (state_q == S_ACCESS);
    accept            = ahbls_hready_resp && ahbls_hready && ahbls_htrans[1];

    case (state_q)
      S_WDATA: begin
        pwdata_d = ahbls_hwdata;
        state_d  = S_SETUP;
      end
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (apbm_pready) begin
          hrdata_d = apbm_prdata;
          state_d  = apbm_pslverr ? S_ERR1 : S_RESP;
        end
      end
      S_ERR1:   state_d = S_ERR2;
      default:  state_d = S_IDLE;
    endcase

    // A new address phase may overlap the final response cycle of the last one.
    if (accept) begin
      paddr_d  = ahbls_haddr[W_PADDR-1:0];
      pwrite_d = ahbls_hwrite;
      pstrb_d  = ahbls_hwrite ? strb_dec : 4'h0;
      state_d  = ahbls_hwrite ? S_WDATA : S_SETUP;
    end
  end

  assign apbm_paddr    = paddr_q;
  assign apbm_pwrite   = pwrite_q;
  assign apbm_pstrb    = pstrb_q;
  assign apbm_pwdata   = pwdata_q;
  assign ahbls_hrdata  = hrdata_q;
  assign ahbls_hexokay = 1'b0;

endmodule
